// File: rtl/pkt_hdr_pkg.sv
// Shared definitions for the packet header stripper.
//   - state_e      : stripper FSM states
//   - *_DFLT       : default geometry and match constants
//   - keep_count() : popcount of a byte-enable vector (zero-extended to KEEP_MAX)
//   - keep_mask()  : low-aligned mask of n ones, (1 << n) - 1
package pkt_hdr_pkg;

  localparam int unsigned DATA_BYTES_DFLT = 32;
  localparam int unsigned HDR_BYTES_DFLT  = 14;
  localparam int unsigned MATCH_OFS_DFLT  = 12;
  localparam logic [15:0] MATCH_VAL_DFLT  = 16'h0008;

  // Widest byte-enable vector the helper functions accept.
  localparam int unsigned KEEP_MAX = 128;

  typedef enum logic [1:0] {
    HEAD  = 2'd0,
    PASS  = 2'd1,
    SHIFT = 2'd2,
    FLUSH = 2'd3
  } state_e;

  function automatic int unsigned keep_count(input logic [KEEP_MAX-1:0] keep);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      cnt += 32'(keep[i]);
    end
    return cnt;
  endfunction

  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned n);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/byte_realigner.sv
// Combinational byte realigner for a fixed HDR_BYTES offset.
//   resid_i   : R = DATA_BYTES-HDR_BYTES carried-over bytes, low-aligned
//   beat_i    : new input beat
//   shifted_o : residual in lanes [R-1:0], new bytes [HDR_BYTES-1:0] in lanes [DATA_BYTES-1:R]
//   resid_o   : new bytes [DATA_BYTES-1:HDR_BYTES], the residual for the next beat
module byte_realigner
  import pkt_hdr_pkg::*;
#(
  parameter int unsigned DATA_BYTES = DATA_BYTES_DFLT,
  parameter int unsigned HDR_BYTES  = HDR_BYTES_DFLT
) (
  input  logic [8*(DATA_BYTES-HDR_BYTES)-1:0] resid_i,
  input  logic [8*DATA_BYTES-1:0]             beat_i,
  output logic [8*DATA_BYTES-1:0]             shifted_o,
  output logic [8*(DATA_BYTES-HDR_BYTES)-1:0] resid_o
);

  always_comb begin
    shifted_o = {beat_i[8*HDR_BYTES-1:0], resid_i};
    resid_o   = beat_i[8*DATA_BYTES-1:8*HDR_BYTES];
  end

endmodule

// File: rtl/pkt_hdr_stripper.sv
// AXI-stream stage that strips a HDR_BYTES header from matching (IPv4) packets and
// re-packs the payload into full low-aligned beats; other packets pass unchanged.
// Keeps saturating counts of stripped and passed packets.
//   clk, reset                          : clock, asynchronous active-high reset
//   strip_en                            : stripping enable, sampled on first beat
//   data_in/tkeep_in/tvalid_in/tlast_in : upstream beat, tready_out back-pressure
//   data_out/tkeep_out/tvalid_out/tlast_out : registered downstream beat, tready_in
//   stat_stripped, stat_passed          : saturating packet counters
module pkt_hdr_stripper
  import pkt_hdr_pkg::*;
#(
  parameter int unsigned DATA_BYTES = DATA_BYTES_DFLT,
  parameter int unsigned HDR_BYTES  = HDR_BYTES_DFLT,
  parameter int unsigned MATCH_OFS  = MATCH_OFS_DFLT,
  parameter logic [15:0] MATCH_VAL  = MATCH_VAL_DFLT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    strip_en,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic [DATA_BYTES-1:0]   tkeep_in,
  input  logic                    tvalid_in,
  input  logic                    tlast_in,
  output logic                    tready_out,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic [DATA_BYTES-1:0]   tkeep_out,
  output logic                    tvalid_out,
  output logic                    tlast_out,
  input  logic                    tready_in,
  output logic [31:0]             stat_stripped,
  output logic [31:0]             stat_passed
);

  localparam int unsigned R = DATA_BYTES - HDR_BYTES;

  state_e                  state_q, state_d;
  logic [8*R-1:0]          resid_q, resid_d;
  logic [DATA_BYTES-1:0]   flush_keep_q, flush_keep_d;

  logic [8*DATA_BYTES-1:0] data_q;
  logic [DATA_BYTES-1:0]   keep_q;
  logic                    last_q;
  logic                    valid_q;
  logic [31:0]             stripped_q;
  logic [31:0]             passed_q;

  logic                    out_free;
  logic                    in_xfer;
  logic                    out_xfer;
  int unsigned             k;
  logic                    type_match;
  logic                    strip_hit;

  logic                    gen;
  logic [8*DATA_BYTES-1:0] beat_data;
  logic [DATA_BYTES-1:0]   beat_keep;
  logic                    beat_last;
  logic                    inc_strip;
  logic                    inc_pass;

  logic [8*DATA_BYTES-1:0] shifted;
  logic [8*R-1:0]          next_resid;

  byte_realigner #(
    .DATA_BYTES (DATA_BYTES),
    .HDR_BYTES  (HDR_BYTES)
  ) u_realigner (
    .resid_i   (resid_q),
    .beat_i    (data_in),
    .shifted_o (shifted),
    .resid_o   (next_resid)
  );

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free   = !valid_q || tready_in;
  assign tready_out = out_free && (state_q != FLUSH);
  assign in_xfer    = tvalid_in && tready_out;
  assign out_xfer   = valid_q && tready_in;

  assign k          = keep_count(KEEP_MAX'(tkeep_in));
  assign type_match = (data_in[8*MATCH_OFS +: 16] == MATCH_VAL);
  // A single-beat packet must carry payload beyond the header to be stripped.
  assign strip_hit  = strip_en && type_match && (!tlast_in || (k > HDR_BYTES));

  always_comb begin
    state_d      = state_q;
    resid_d      = resid_q;
    flush_keep_d = flush_keep_q;
    gen          = 1'b0;
    beat_data    = '0;
    beat_keep    = '0;
    beat_last    = 1'b0;
    inc_strip    = 1'b0;
    inc_pass     = 1'b0;

    case (state_q)
      HEAD: begin
        if (in_xfer) begin
          if (strip_hit) begin
            inc_strip = 1'b1;
            resid_d   = next_resid;
            if (tlast_in) begin
              gen       = 1'b1;
              beat_data = {{(8*HDR_BYTES){1'b0}}, next_resid};
              beat_keep = DATA_BYTES'(keep_mask(k - HDR_BYTES));
              beat_last = 1'b1;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            inc_pass  = 1'b1;
            gen       = 1'b1;
            beat_data = data_in;
            beat_keep = tkeep_in;
            beat_last = tlast_in;
            if (!tlast_in) begin
              state_d = PASS;
            end
          end
        end
      end

      PASS: begin
        if (in_xfer) begin
          gen       = 1'b1;
          beat_data = data_in;
          beat_keep = tkeep_in;
          beat_last = tlast_in;
          if (tlast_in) begin
            state_d = HEAD;
          end
        end
      end

      SHIFT: begin
        if (in_xfer) begin
          gen       = 1'b1;
          beat_data = shifted;
          beat_keep = '1;
          resid_d   = next_resid;
          if (tlast_in) begin
            if (k <= HDR_BYTES) begin
              beat_keep = DATA_BYTES'(keep_mask(R + k));
              beat_last = 1'b1;
              state_d   = HEAD;
            end else begin
              // Payload spills past this beat; the leftover goes out from FLUSH.
              flush_keep_d = DATA_BYTES'(keep_mask(k - HDR_BYTES));
              state_d      = FLUSH;
            end
          end
        end
      end

      FLUSH: begin
        if (out_free) begin
          gen       = 1'b1;
          beat_data = {{(8*HDR_BYTES){1'b0}}, resid_q};
          beat_keep = flush_keep_q;
          beat_last = 1'b1;
          state_d   = HEAD;
        end
      end

      default: state_d = HEAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HEAD;
      resid_q      <= '0;
      flush_keep_q <= '0;
    end else begin
      state_q      <= state_d;
      resid_q      <= resid_d;
      flush_keep_q <= flush_keep_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (gen) begin
      data_q  <= beat_data;
      keep_q  <= beat_keep;
      last_q  <= beat_last;
      valid_q <= 1'b1;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stripped_q <= '0;
      passed_q   <= '0;
    end else begin
      if (inc_strip && (stripped_q != 32'hFFFF_FFFF)) begin
        stripped_q <= stripped_q + 32'd1;
      end
      if (inc_pass && (passed_q != 32'hFFFF_FFFF)) begin
        passed_q <= passed_q + 32'd1;
      end
    end
  end

  assign data_out      = data_q;
  assign tkeep_out     = keep_q;
  assign tlast_out     = last_q;
  assign tvalid_out    = valid_q;
  assign stat_stripped = stripped_q;
  assign stat_passed   = passed_q;

endmodule
